// File: rtl/pinball_ball_renderer.sv
// Pinball ball renderer: one physics step per frame on the vsync falling edge, plus
// registered RGB for ball, three walls and background.
module pinball_ball_renderer #(
    parameter int BALL_SIZE = 8,
    parameter int START_X   = 600,
    parameter int START_Y   = 440,
    parameter int LAUNCH_VX = -2,
    parameter int LAUNCH_VY = -12,
    parameter int GRAVITY   = 1,
    parameter int GRAV_DIV  = 4,
    parameter int VMAX      = 12,
    parameter int XMIN      = 8,
    parameter int XMAX      = 631,
    parameter int YMIN      = 8,
    parameter int YMAX      = 479
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [11:0] i_x,
    input  logic [11:0] i_y,
    input  logic        i_vsync,
    input  logic        i_launch,
    output logic [3:0]  o_red,
    output logic [3:0]  o_green,
    output logic [3:0]  o_blue,
    output logic [11:0] o_ball_x,
    output logic [11:0] o_ball_y,
    output logic        o_ball_lost
);

    typedef enum logic [2:0] {StHold, StIdle, StUpdX, StUpdY, StGrav} state_t;

    localparam logic [11:0]        START_X12 = 12'(START_X);
    localparam logic [11:0]        START_Y12 = 12'(START_Y);
    localparam logic signed [7:0]  VX0       = 8'(LAUNCH_VX);
    localparam logic signed [7:0]  VY0       = 8'(LAUNCH_VY);
    localparam logic signed [8:0]  GRAV9     = 9'(GRAVITY);
    localparam logic signed [8:0]  VMAX9     = 9'(VMAX);
    localparam logic [7:0]         GRAV_LAST = 8'(GRAV_DIV - 1);
    // Clamp positions: the farthest top-left coordinate that keeps the ball inside.
    localparam logic signed [12:0] X_LO      = 13'(XMIN);
    localparam logic signed [12:0] X_HI      = 13'(XMAX - BALL_SIZE + 1);
    localparam logic signed [12:0] Y_LO      = 13'(YMIN);
    localparam logic signed [12:0] Y_HI      = 13'(YMAX - BALL_SIZE + 1);
    localparam logic [12:0]        SIZE13    = 13'(BALL_SIZE);

    state_t             r_state, w_state_next;
    logic [11:0]        r_ball_x, w_ball_x_next;
    logic [11:0]        r_ball_y, w_ball_y_next;
    logic signed [7:0]  r_vx, w_vx_next;
    logic signed [7:0]  r_vy, w_vy_next;
    logic [7:0]         r_grav_cnt, w_grav_cnt_next;
    logic               r_vsync_d;
    logic               r_ball_lost, w_ball_lost_next;
    logic [11:0]        r_rgb, w_rgb_next;

    logic               w_tick;
    logic signed [12:0] w_nx, w_ny;
    logic signed [8:0]  w_vy_sum;
    logic               w_in_ball;

    assign w_tick   = r_vsync_d & ~i_vsync;
    assign w_nx     = $signed({1'b0, r_ball_x}) + $signed({{5{r_vx[7]}}, r_vx});
    assign w_ny     = $signed({1'b0, r_ball_y}) + $signed({{5{r_vy[7]}}, r_vy});
    assign w_vy_sum = $signed({r_vy[7], r_vy}) + GRAV9;

    always_comb begin
        w_state_next     = r_state;
        w_ball_x_next    = r_ball_x;
        w_ball_y_next    = r_ball_y;
        w_vx_next        = r_vx;
        w_vy_next        = r_vy;
        w_grav_cnt_next  = r_grav_cnt;
        w_ball_lost_next = 1'b0;
        unique case (r_state)
            StHold: begin
                w_ball_x_next = START_X12;
                w_ball_y_next = START_Y12;
                if (w_tick && i_launch) begin
                    w_vx_next       = VX0;
                    w_vy_next       = VY0;
                    w_grav_cnt_next = 8'd0;
                    w_state_next    = StIdle;
                end
            end
            StIdle: begin
                if (w_tick) w_state_next = StUpdX;
            end
            StUpdX: begin
                if (w_nx < X_LO) begin
                    w_ball_x_next = X_LO[11:0];
                    w_vx_next     = -r_vx;
                end else if (w_nx > X_HI) begin
                    w_ball_x_next = X_HI[11:0];
                    w_vx_next     = -r_vx;
                end else begin
                    w_ball_x_next = w_nx[11:0];
                end
                w_state_next = StUpdY;
            end
            StUpdY: begin
                if (w_ny < Y_LO) begin
                    w_ball_y_next = Y_LO[11:0];
                    w_vy_next     = -r_vy;
                    w_state_next  = StGrav;
                end else if (w_ny > Y_HI) begin
                    // Open bottom edge: the ball drains back to the plunger.
                    w_ball_lost_next = 1'b1;
                    w_ball_x_next    = START_X12;
                    w_ball_y_next    = START_Y12;
                    w_vx_next        = 8'sd0;
                    w_vy_next        = 8'sd0;
                    w_state_next     = StHold;
                end else begin
                    w_ball_y_next = w_ny[11:0];
                    w_state_next  = StGrav;
                end
            end
            StGrav: begin
                if (r_grav_cnt == GRAV_LAST) begin
                    w_grav_cnt_next = 8'd0;
                    w_vy_next       = (w_vy_sum > VMAX9) ? VMAX9[7:0] : w_vy_sum[7:0];
                end else begin
                    w_grav_cnt_next = r_grav_cnt + 8'd1;
                end
                w_state_next = StIdle;
            end
            default: w_state_next = StHold;
        endcase
    end

    assign w_in_ball = ({1'b0, i_x} >= {1'b0, r_ball_x}) &&
                       ({1'b0, i_x} <  ({1'b0, r_ball_x} + SIZE13)) &&
                       ({1'b0, i_y} >= {1'b0, r_ball_y}) &&
                       ({1'b0, i_y} <  ({1'b0, r_ball_y} + SIZE13));

    always_comb begin
        w_rgb_next = 12'h020;
        if (i_x == 12'd0 || i_y == 12'd0) begin
            w_rgb_next = 12'h000;
        end else if (w_in_ball) begin
            w_rgb_next = 12'hFFF;
        end else if (i_x < 12'(XMIN) || i_x > 12'(XMAX) || i_y < 12'(YMIN)) begin
            w_rgb_next = 12'h00F;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= StHold;
            r_ball_x    <= START_X12;
            r_ball_y    <= START_Y12;
            r_vx        <= 8'sd0;
            r_vy        <= 8'sd0;
            r_grav_cnt  <= 8'd0;
            r_vsync_d   <= 1'b1;
            r_ball_lost <= 1'b0;
            r_rgb       <= 12'h000;
        end else begin
            r_state     <= w_state_next;
            r_ball_x    <= w_ball_x_next;
            r_ball_y    <= w_ball_y_next;
            r_vx        <= w_vx_next;
            r_vy        <= w_vy_next;
            r_grav_cnt  <= w_grav_cnt_next;
            r_vsync_d   <= i_vsync;
            r_ball_lost <= w_ball_lost_next;
            r_rgb       <= w_rgb_next;
        end
    end

    assign o_red       = r_rgb[11:8];
    assign o_green     = r_rgb[7:4];
    assign o_blue      = r_rgb[3:0];
    assign o_ball_x    = r_ball_x;
    assign o_ball_y    = r_ball_y;
    assign o_ball_lost = r_ball_lost;

endmodule

// File: tb/tb_pinball_ball_renderer.sv
// Directed bench: default-parameter flight to the drain, plus a second instance with a
// raised left wall and no gravity to exercise wall and ceiling bounces.
module tb_pinball_ball_renderer;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] x, y;
    logic        vsync, launch;
    logic [3:0]  red, green, blue;
    logic [11:0] ball_x, ball_y;
    logic        ball_lost;
    logic [3:0]  w_red, w_green, w_blue;
    logic [11:0] w_ball_x, w_ball_y;
    logic        w_ball_lost;

    int checks = 0;
    int errors = 0;
    int lost_cnt = 0;

    always #5 clk = ~clk;

    pinball_ball_renderer u_dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_x         (x),
        .i_y         (y),
        .i_vsync     (vsync),
        .i_launch    (launch),
        .o_red       (red),
        .o_green     (green),
        .o_blue      (blue),
        .o_ball_x    (ball_x),
        .o_ball_y    (ball_y),
        .o_ball_lost (ball_lost)
    );

    pinball_ball_renderer #(
        .START_X   (620),
        .START_Y   (20),
        .LAUNCH_VX (6),
        .LAUNCH_VY (-5),
        .GRAVITY   (0),
        .XMIN      (605)
    ) u_dut_w (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_x         (x),
        .i_y         (y),
        .i_vsync     (vsync),
        .i_launch    (launch),
        .o_red       (w_red),
        .o_green     (w_green),
        .o_blue      (w_blue),
        .o_ball_x    (w_ball_x),
        .o_ball_y    (w_ball_y),
        .o_ball_lost (w_ball_lost)
    );

    always @(negedge clk) if (ball_lost) lost_cnt++;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frame();
        vsync = 1'b0;
        step(4);
        vsync = 1'b1;
        step(4);
    endtask

    task automatic pix(input string tag, input int px, input int py, input int exp);
        x = 12'(px);
        y = 12'(py);
        step(1);
        check(tag, int'({red, green, blue}), exp);
    endtask

    initial begin
        rst    = 1'b1;
        x      = 12'd300;
        y      = 12'd300;
        vsync  = 1'b1;
        launch = 1'b0;
        step(2);
        check("rst_rgb", int'({red, green, blue}), 'h000);
        check("rst_ball_x", int'(ball_x), 600);
        check("rst_ball_y", int'(ball_y), 440);
        check("rst_lost", int'(ball_lost), 0);
        rst = 1'b0;
        step(1);
        check("bg_after_rst", int'({red, green, blue}), 'h020);

        repeat (5) frame();
        check("hold_x", int'(ball_x), 600);
        check("hold_y", int'(ball_y), 440);
        check("hold_w_x", int'(w_ball_x), 620);
        check("hold_w_y", int'(w_ball_y), 20);

        pix("ball_tl", 600, 440, 'hFFF);
        pix("ball_br", 607, 447, 'hFFF);
        pix("ball_right_out", 608, 440, 'h020);
        pix("ball_left_out", 599, 440, 'h020);
        pix("left_wall", 3, 100, 'h00F);
        pix("right_wall", 635, 200, 'h00F);
        pix("top_wall", 300, 5, 'h00F);
        pix("background", 300, 300, 'h020);
        pix("x_zero", 0, 300, 'h000);
        pix("y_zero_on_ball_col", 600, 0, 'h000);
        x = 12'd0;
        y = 12'd0;

        launch = 1'b1;
        frame();
        check("launch_frame_x", int'(ball_x), 600);
        check("launch_frame_y", int'(ball_y), 440);

        // Launch stays high through the flight; it must have no effect outside HOLD.
        for (int f = 1; f <= 103; f++) begin
            frame();
            if (f == 1) begin
                check("f1_x", int'(ball_x), 598);
                check("f1_y", int'(ball_y), 428);
                check("w_f1_x_rwall", int'(w_ball_x), 624);
                check("w_f1_y", int'(w_ball_y), 15);
            end
            if (f == 3) begin
                check("w_f3_x", int'(w_ball_x), 612);
                check("w_f3_y_ceiling", int'(w_ball_y), 8);
            end
            if (f == 4) begin
                check("f4_x", int'(ball_x), 592);
                check("f4_y", int'(ball_y), 392);
                check("w_f4_y", int'(w_ball_y), 13);
            end
            if (f == 5) begin
                check("f5_y_grav", int'(ball_y), 381);
                check("w_f5_x_lwall", int'(w_ball_x), 605);
                check("w_f5_y", int'(w_ball_y), 18);
            end
            if (f == 6) begin
                check("w_f6_x", int'(w_ball_x), 611);
                check("w_f6_y", int'(w_ball_y), 23);
            end
            if (f == 48) check("f48_peak_y", int'(ball_y), 128);
            if (f == 100) check("f100_y", int'(ball_y), 440);
            if (f == 101) check("f101_y_vmax", int'(ball_y), 452);
            if (f == 102) begin
                check("f102_x", int'(ball_x), 396);
                check("f102_y", int'(ball_y), 464);
                check("lost_before_drain", lost_cnt, 0);
            end
        end
        check("drain_pulse_cnt", lost_cnt, 1);
        check("drain_x", int'(ball_x), 600);
        check("drain_y", int'(ball_y), 440);

        launch = 1'b0;
        repeat (2) frame();
        check("post_drain_hold_x", int'(ball_x), 600);
        check("post_drain_hold_y", int'(ball_y), 440);
        check("post_drain_pulse_cnt", lost_cnt, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
